// File: rtl/updown_counter.sv
// Parametrised up/down event counter with enable prescaler, synchronous load/clear,
// wrap-or-saturate bounds, a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               PRESCALE = 1,
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] r_out;
    logic [PW-1:0]    r_presc;
    logic             r_tc;
    logic             r_ovf;

    logic             w_presc_last;
    logic             w_step;
    logic             w_at_bound;
    logic             w_event;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_presc_last   = (r_presc == PRESC_LAST);
    // clr and load pre-empt the step, so a suppressed step can never raise ovf.
    assign w_step         = en && !clr && !load && w_presc_last;
    assign w_at_bound     = dir ? (r_out == MAX_VAL) : (r_out == '0);
    assign w_event        = w_step && w_at_bound;
    assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        w_next = r_out;
        if (dir) begin
            if (w_at_bound) w_next = (SATURATE != 0) ? MAX_VAL : '0;
            else            w_next = r_out + 1'b1;
        end else begin
            if (w_at_bound) w_next = (SATURATE != 0) ? '0 : MAX_VAL;
            else            w_next = r_out - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out   <= '0;
            r_presc <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            // A boundary event beats a coincident ovf_clr.
            if (w_event)      r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;

            if (clr) begin
                r_out   <= '0;
                r_presc <= '0;
            end else if (load) begin
                r_out   <= w_load_clamped;
                r_presc <= '0;
            end else if (en) begin
                if (w_presc_last) begin
                    r_presc <= '0;
                    r_out   <= w_next;
                    r_tc    <= w_at_bound;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign out = r_out;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: three instances (wrap, saturate, prescale-by-3)
// share one stimulus bus; each phase resets and checks the instance it targets.
module tb_updown_counter;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic       clr;
  logic       ovf_clr;

  logic [3:0] out_w, out_s, out_p;
  logic       tc_w, tc_s, tc_p;
  logic       ovf_w, ovf_s, ovf_p;

  int checks;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr(clr), .ovf_clr(ovf_clr), .out(out_w), .tc(tc_w), .ovf(ovf_w)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1), .SATURATE(1)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr(clr), .ovf_clr(ovf_clr), .out(out_s), .tc(tc_s), .ovf(ovf_s)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3), .SATURATE(0)) u_pre (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr(clr), .ovf_clr(ovf_clr), .out(out_p), .tc(tc_p), .ovf(ovf_p)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] lv;
    logic       clr;
    logic       oc;
    logic [3:0] eo;
    logic       etc;
    logic       eov;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic a_en, input logic a_dir, input logic a_load,
                     input logic [3:0] a_lv, input logic a_clr, input logic a_oc,
                     input logic [3:0] a_eo, input logic a_etc, input logic a_eov);
    vec_t v;
    v.en = a_en; v.dir = a_dir; v.load = a_load; v.lv = a_lv;
    v.clr = a_clr; v.oc = a_oc; v.eo = a_eo; v.etc = a_etc; v.eov = a_eov;
    vq.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_en, input logic a_dir, input logic a_load,
                       input logic [3:0] a_lv, input logic a_clr, input logic a_oc);
    en = a_en; dir = a_dir; load = a_load; load_val = a_lv; clr = a_clr; ovf_clr = a_oc;
    tick();
  endtask

  task automatic do_reset();
    en = 0; dir = 0; load = 0; load_val = 0; clr = 0; ovf_clr = 0;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;

    // Wrap instance: up-wrap, down-wrap, ovf clear, set-wins, priority, clamp.
    for (int c = 1; c <= 12; c++)
      add(1, 1, 0, 0, 0, 0, 4'(c % 10), (c == 10), (c >= 10));
    add(0, 0, 1, 2, 0, 0, 2, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 9, 1, 1);
    add(1, 0, 0, 0, 0, 0, 8, 0, 1);
    add(0, 0, 0, 0, 0, 1, 8, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 9, 1, 1);
    add(0, 0, 0, 0, 0, 0, 9, 0, 1);
    add(0, 1, 1, 5, 1, 0, 0, 0, 1);
    add(0, 1, 1, 15, 0, 0, 9, 0, 1);
    add(1, 1, 0, 0, 1, 0, 0, 0, 1);

    do_reset();
    check("reset_out", out_w, 0);
    check("reset_tc", {3'b0, tc_w}, 0);
    check("reset_ovf", {3'b0, ovf_w}, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].dir, vq[i].load, vq[i].lv, vq[i].clr, vq[i].oc);
      check($sformatf("vec%0d_out", i), out_w, vq[i].eo);
      check($sformatf("vec%0d_tc", i), {3'b0, tc_w}, {3'b0, vq[i].etc});
      check($sformatf("vec%0d_ovf", i), {3'b0, ovf_w}, {3'b0, vq[i].eov});
    end

    // Saturate: pinned at MAX_VAL and at 0, tc pulses per attempted step.
    do_reset();
    drive(0, 0, 1, 8, 0, 0); check("sat_load", out_s, 8);
    drive(1, 1, 0, 0, 0, 0); check("sat_up1", out_s, 9); check("sat_up1_tc", {3'b0, tc_s}, 0);
    check("sat_up1_ovf", {3'b0, ovf_s}, 0);
    drive(1, 1, 0, 0, 0, 0); check("sat_up2", out_s, 9); check("sat_up2_tc", {3'b0, tc_s}, 1);
    check("sat_up2_ovf", {3'b0, ovf_s}, 1);
    drive(1, 1, 0, 0, 0, 0); check("sat_up3", out_s, 9); check("sat_up3_tc", {3'b0, tc_s}, 1);
    drive(0, 0, 1, 0, 0, 1); check("sat_ld0", out_s, 0); check("sat_ld0_ovf", {3'b0, ovf_s}, 0);
    drive(1, 0, 0, 0, 0, 0); check("sat_dn", out_s, 0); check("sat_dn_tc", {3'b0, tc_s}, 1);
    check("sat_dn_ovf", {3'b0, ovf_s}, 1);
    drive(0, 0, 0, 0, 0, 0); check("sat_idle_tc", {3'b0, tc_s}, 0);

    // Prescaler: one step per three enabled cycles, phase held while en=0.
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      drive(1, 1, 0, 0, 0, 0);
      check($sformatf("pre_c%0d", c), out_p, 4'(c / 3));
    end
    drive(1, 1, 0, 0, 0, 0); check("pre_gap_a", out_p, 3);
    drive(0, 1, 0, 0, 0, 0); check("pre_gap_b", out_p, 3);
    drive(0, 1, 0, 0, 0, 0); check("pre_gap_c", out_p, 3);
    drive(1, 1, 0, 0, 0, 0); check("pre_gap_d", out_p, 3);
    drive(1, 1, 0, 0, 0, 0); check("pre_gap_step", out_p, 4);
    drive(1, 1, 0, 0, 0, 0); check("pre_ld_a", out_p, 4);
    drive(1, 1, 1, 7, 0, 0); check("pre_ld", out_p, 7);
    drive(1, 1, 0, 0, 0, 0); check("pre_ld_p1", out_p, 7);
    drive(1, 1, 0, 0, 0, 0); check("pre_ld_p2", out_p, 7);
    drive(1, 1, 0, 0, 0, 0); check("pre_ld_step", out_p, 8);

    // Asynchronous reset between edges while out=5 and ovf=1.
    do_reset();
    drive(0, 0, 1, 9, 0, 0);
    drive(1, 1, 0, 0, 0, 0); check("ar_wrap_tc", {3'b0, tc_w}, 1);
    drive(0, 0, 1, 5, 0, 0); check("ar_pre_out", out_w, 5); check("ar_pre_ovf", {3'b0, ovf_w}, 1);
    en = 0; load = 0; load_val = 0;
    #2 rstn = 1'b0;
    #1;
    check("ar_out", out_w, 0);
    check("ar_tc", {3'b0, tc_w}, 0);
    check("ar_ovf", {3'b0, ovf_w}, 0);
    #2 rstn = 1'b1;
    drive(1, 1, 0, 0, 0, 0); check("ar_rel1_w", out_w, 1); check("ar_rel1_p", out_p, 0);
    drive(1, 1, 0, 0, 0, 0); check("ar_rel2_p", out_p, 0);
    drive(1, 1, 0, 0, 0, 0); check("ar_rel3_p", out_p, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
